alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_mul_seq.sv | 53 +++++
 rtl/alu_mc.sv | 172 +++++++++++++++++
 tb/tb_alu_mc.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcode encodings and controller states.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_XOR   = 4'b0011,
        OP_SUB   = 4'b0110,
        OP_PASSB = 4'b0111,
        OP_LSL   = 4'b1000,
        OP_LSR   = 4'b1001,
        OP_ASR   = 4'b1010,
        OP_MUL   = 4'b1100
    } alu_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier: N steps total, the first taken on the start cycle,
// the rest one per cycle; o_product holds the low N bits of the unsigned product.
module alu_mul_seq #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_start,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic         o_busy,
    output logic         o_done,
    output logic [N-1:0] o_product
);
    localparam int CW = $clog2(N) + 1;

    logic [N-1:0]  r_prod;
    logic [N-1:0]  r_mcand;
    logic [N-1:0]  r_mplier;
    logic [CW-1:0] r_cnt;
    logic          r_active;

    // r_cnt counts the remaining steps after the one folded into the start cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prod   <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (i_start) begin
            r_prod   <= i_b[0] ? i_a : '0;
            r_mcand  <= i_a << 1;
            r_mplier <= i_b >> 1;
            r_cnt    <= CW'(N - 1);
            r_active <= 1'b1;
        end else if (r_active) begin
            if (r_cnt != '0) begin
                r_prod   <= r_prod + (r_mplier[0] ? r_mcand : '0);
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt - 1'b1;
            end else begin
                r_active <= 1'b0;
            end
        end
    end

    assign o_busy    = r_active;
    assign o_done    = r_active && (r_cnt == '0);
    assign o_product = r_prod;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes and registered result and flags.
// Define ALU_MC_MUL_EN to build the sequential multiplier (opcode 1100); otherwise MUL is undefined.
module alu_mc
    import alu_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   ALUControl,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         zero,
    output logic         negative,
    output logic         carry,
    output logic         overflow
);
    localparam int SW = $clog2(N);

    alu_state_t     r_state;
    alu_state_t     w_state_next;
    logic [N-1:0]   r_result;
    logic           r_zero;
    logic           r_negative;
    logic           r_carry;
    logic           r_overflow;

    logic           w_load;
    logic [N-1:0]   w_res;
    logic           w_c;
    logic           w_v;
    logic [N:0]     w_sum;
    logic [N-1:0]   w_diff;
    logic [SW-1:0]  w_sh;

`ifdef ALU_MC_MUL_EN
    logic           w_start;
    logic           w_load_mul;
    logic           w_mul_busy;
    logic           w_mul_done;
    logic [N-1:0]   w_product;

    alu_mul_seq #(.N(N)) u_mul (
        .clk       (clk),
        .reset     (reset),
        .i_start   (w_start),
        .i_a       (a),
        .i_b       (b),
        .o_busy    (w_mul_busy),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );
`endif

    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = a - b;
    assign w_sh   = b[SW-1:0];

    // Single-cycle datapath works on the live inputs; they are captured at accept.
    always_comb begin
        w_res = '1;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (ALUControl)
            OP_AND:   w_res = a & b;
            OP_OR:    w_res = a | b;
            OP_XOR:   w_res = a ^ b;
            OP_ADD: begin
                w_res = w_sum[N-1:0];
                w_c   = w_sum[N];
                w_v   = (a[N-1] == b[N-1]) && (w_sum[N-1] != a[N-1]);
            end
            OP_SUB: begin
                w_res = w_diff;
                w_c   = (a >= b);
                w_v   = (a[N-1] != b[N-1]) && (w_diff[N-1] != a[N-1]);
            end
            OP_PASSB: w_res = b;
            OP_LSL:   w_res = a << w_sh;
            OP_LSR:   w_res = a >> w_sh;
            OP_ASR:   w_res = $unsigned($signed(a) >>> w_sh);
            default:  w_res = '1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
`ifdef ALU_MC_MUL_EN
        w_start      = 1'b0;
        w_load_mul   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
`ifdef ALU_MC_MUL_EN
                    if (ALUControl == OP_MUL) begin
                        w_start      = 1'b1;
                        w_state_next = S_BUSY;
                    end else begin
                        w_load       = 1'b1;
                        w_state_next = S_DONE;
                    end
`else
                    w_load       = 1'b1;
                    w_state_next = S_DONE;
`endif
                end
            end
            S_BUSY: begin
`ifdef ALU_MC_MUL_EN
                if (w_mul_done) begin
                    w_load_mul   = 1'b1;
                    w_state_next = S_DONE;
                end else if (!w_mul_busy) begin
                    w_state_next = S_IDLE;
                end
`else
                w_state_next = S_IDLE;
`endif
            end
            S_DONE: begin
                if (out_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_negative <= 1'b0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_load) begin
            r_result   <= w_res;
            r_zero     <= (w_res == '0);
            r_negative <= w_res[N-1];
            r_carry    <= w_c;
            r_overflow <= w_v;
        end
`ifdef ALU_MC_MUL_EN
        else if (w_load_mul) begin
            r_result   <= w_product;
            r_zero     <= (w_product == '0);
            r_negative <= w_product[N-1];
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
        end
`endif
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign zero      = r_zero;
    assign negative  = r_negative;
    assign carry     = r_carry;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: a 64-bit instance for arithmetic/handshake cases, an 8-bit one for shifts.
module tb_alu_mc;
    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        iv64 = 1'b0, ir64, ov64, or64 = 1'b0;
    logic [63:0] a64 = '0, b64 = '0, res64;
    logic [3:0]  op64 = '0;
    logic        z64, n64, c64, v64;

    logic        iv8 = 1'b0, ir8, ov8, or8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0, res8;
    logic [3:0]  op8 = '0;
    logic        z8, n8, c8, v8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_mc #(.N(64)) dut64 (
        .clk(clk), .reset(reset), .in_valid(iv64), .in_ready(ir64),
        .a(a64), .b(b64), .ALUControl(op64), .out_valid(ov64), .out_ready(or64),
        .result(res64), .zero(z64), .negative(n64), .carry(c64), .overflow(v64)
    );

    alu_mc #(.N(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .ALUControl(op8), .out_valid(ov8), .out_ready(or8),
        .result(res8), .zero(z8), .negative(n8), .carry(c8), .overflow(v8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // flags packed as {zero, negative, carry, overflow}
    task automatic run64(input string tag, input logic [3:0] op, input logic [63:0] av,
                         input logic [63:0] bv, input logic [63:0] er, input logic [3:0] ef,
                         input int elat);
        int k;
        logic busy_ok;
        @(negedge clk);
        iv64 = 1'b1; op64 = op; a64 = av; b64 = bv;
        @(posedge clk); #1;
        iv64 = 1'b0; a64 = '0; b64 = '0; op64 = 4'b0000;
        k = 1;
        busy_ok = 1'b1;
        while (!ov64 && k < 200) begin
            if (ir64) busy_ok = 1'b0;
            @(posedge clk); #1;
            k++;
        end
        chk({tag, "_lat"}, 64'(k), 64'(elat));
        chk({tag, "_busy_rdy"}, {63'd0, busy_ok}, 64'd1);
        chk({tag, "_res"}, res64, er);
        chk({tag, "_flags"}, {60'd0, z64, n64, c64, v64}, {60'd0, ef});
        @(negedge clk); or64 = 1'b1;
        @(posedge clk); #1; or64 = 1'b0;
        chk({tag, "_idle"}, {62'd0, ir64, ov64}, 64'b10);
    endtask

    task automatic run8(input string tag, input logic [3:0] op, input logic [7:0] av,
                        input logic [7:0] bv, input logic [7:0] er, input logic [3:0] ef);
        @(negedge clk);
        iv8 = 1'b1; op8 = op; a8 = av; b8 = bv;
        @(posedge clk); #1;
        iv8 = 1'b0; a8 = '0; b8 = '0;
        chk({tag, "_ov"}, {63'd0, ov8}, 64'd1);
        chk({tag, "_res"}, {56'd0, res8}, {56'd0, er});
        chk({tag, "_flags"}, {60'd0, z8, n8, c8, v8}, {60'd0, ef});
        @(negedge clk); or8 = 1'b1;
        @(posedge clk); #1; or8 = 1'b0;
    endtask

    initial begin
        logic [63:0] held;
        #2;
        chk("rst_res", res64, 64'd0);
        chk("rst_flags", {60'd0, z64, n64, c64, v64}, 64'd0);
        chk("rst_hs", {62'd0, ir64, ov64}, 64'b10);
        @(negedge clk); reset = 1'b0;

        run64("add_wrap", 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'b1010, 1);
        run64("sub_ovf", 4'b0110, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
              64'h8000_0000_0000_0000, 4'b0101, 1);
        run64("sub_nb", 4'b0110, 64'd5, 64'd3, 64'd2, 4'b0010, 1);
        run64("sub_eq", 4'b0110, 64'd7, 64'd7, 64'd0, 4'b1010, 1);
        run64("add_sov", 4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
              64'h8000_0000_0000_0000, 4'b0101, 1);
        run64("and", 4'b0000, 64'hF0F0, 64'hFF00, 64'hF000, 4'b0000, 1);
        run64("or", 4'b0001, 64'hF0F0, 64'h0F0F, 64'hFFFF, 4'b0000, 1);
        run64("xor", 4'b0011, 64'hAAAA, 64'hAAAA, 64'd0, 4'b1000, 1);
        run64("passb", 4'b0111, 64'd1, 64'h8000_0000_0000_0001,
              64'h8000_0000_0000_0001, 4'b0100, 1);
        run64("lsl", 4'b1000, 64'd1, 64'h44, 64'h10, 4'b0000, 1);
        run64("undef", 4'b1111, 64'd3, 64'd4, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0100, 1);
`ifdef ALU_MC_MUL_EN
        run64("mul", 4'b1100, 64'd12345, 64'd678, 64'd8369910, 4'b0000, 65);
`else
        run64("mul", 4'b1100, 64'd12345, 64'd678, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0100, 1);
`endif

        run8("asr", 4'b1010, 8'h90, 8'h0B, 8'hF2, 4'b0100);
        run8("lsr", 4'b1001, 8'h90, 8'h0B, 8'h12, 4'b0000);

        // backpressure: DONE holds while out_ready is low, new requests ignored
        @(negedge clk);
        iv64 = 1'b1; op64 = 4'b0010; a64 = 64'd100; b64 = 64'd23;
        @(posedge clk); #1;
        a64 = 64'd1; b64 = 64'd1; op64 = 4'b0110;
        held = res64;
        chk("bp_first", held, 64'd123);
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("bp_res", res64, 64'd123);
        chk("bp_flags", {60'd0, z64, n64, c64, v64}, 64'd0);
        chk("bp_hs", {62'd0, ir64, ov64}, 64'b01);
        iv64 = 1'b0;
        @(negedge clk); or64 = 1'b1;
        @(posedge clk); #1; or64 = 1'b0;
        chk("bp_rel", {62'd0, ir64, ov64}, 64'b10);
        @(posedge clk); #1;
        chk("bp_idle_hold", res64, 64'd123);

        // abort mid-operation with reset
        @(negedge clk);
        iv64 = 1'b1; op64 = 4'b1100; a64 = 64'd12345; b64 = 64'd678;
        or64 = 1'b0;
        @(posedge clk); #1;
        iv64 = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        chk("abort_hs", {62'd0, ir64, ov64}, 64'b10);
        chk("abort_res", res64, 64'd0);
        chk("abort_flags", {60'd0, z64, n64, c64, v64}, 64'd0);
        @(negedge clk); reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_quiet", {62'd0, ir64, ov64}, 64'b10);
        run64("post_add", 4'b0010, 64'd2, 64'd3, 64'd5, 4'b0000, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
